id_ex_pipeline_reg: RTL and testbench

Decode-to-execute pipeline register for the RISC-V core. It sits directly downstream of the decode register file and captures the decoded instruction fields and the two register-file read operands. It presents them to the execute stage under a valid/ready handshake. It also handles writeback bypass into captured operands, load-use bubble insertion, branch flush, and a saturating stall counter.

---
 rtl/id_ex_pipeline_reg.sv | 113 +++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register. Holds one decoded instruction for EX
// under a valid/ready handshake. Also handles writeback bypass into the held
// operands, load-use bubble insertion, branch flush and a saturating stall counter.
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic load, hazard;
  logic wb_hit;
  logic byp_id1, byp_id2, byp_ex1, byp_ex2;

  // ex_mem_read is already forced to 0 while empty, so no extra ex_valid term
  // is strictly needed, but it keeps the intent readable.
  assign load    = ~ex_valid | ex_ready;
  assign hazard  = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign id_ready = flush | (load & ~hazard);

  // x0 is hardwired zero, so a write to it must never be forwarded.
  assign wb_hit  = wb_we & (wb_rd != '0);
  assign byp_id1 = wb_hit & (wb_rd == id_rs1);
  assign byp_id2 = wb_hit & (wb_rd == id_rs2);
  assign byp_ex1 = wb_hit & (wb_rd == ex_rs1);
  assign byp_ex2 = wb_hit & (wb_rd == ex_rs2);

  // Held instruction: reset, kill (flush/bubble/empty), capture, or hold with bypass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush || (load && (hazard || !id_valid))) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rd1       <= byp_id1 ? wb_data : id_rd1;
      ex_rd2       <= byp_id2 ? wb_data : id_rd2;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_alu_op    <= id_alu_op;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
    end else begin
      // Stalled by EX: keep the held operands fresh against writeback.
      if (byp_ex1) ex_rd1 <= wb_data;
      if (byp_ex2) ex_rd2 <= wb_data;
    end
  end

  // Count decode cycles that were refused, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cycles <= '0;
    else if (id_valid && !id_ready && stall_cycles != CNT_MAX)
      stall_cycles <= stall_cycles + CNT_ONE;
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_id_ex_pipeline_reg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int CW   = 4;   // narrow counter so saturation is reachable

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_ready;
  logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_alu_op;
  logic id_reg_write, id_mem_read, id_mem_write;
  logic wb_we;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic flush, ex_ready, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  logic ex_reg_write, ex_mem_read, ex_mem_write;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .stall_cycles(stall_cycles)
  );

  // Reference view of the instruction sitting in front of EX.
  typedef struct packed {
    logic v;
    logic [XLEN-1:0] pc, imm, rd1, rd2;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [3:0] op;
    logic rw, mr, mw;
  } ex_t;

  ex_t m;
  logic [CW-1:0] mcnt;
  bit init = 0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Source operand value the instruction should see, given this cycle's writeback.
  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] d);
    return (wb_we && wb_rd != 0 && wb_rd == rs) ? wb_data : d;
  endfunction

  function automatic bit load_use();
    return id_valid && m.v && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  function automatic bit exp_ready();
    bit stuck;
    stuck = m.v && !ex_ready;
    return flush || (!stuck && !load_use());
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    ex_t n;
    bit stuck, lu, rdy;
    stuck = m.v && !ex_ready;
    lu    = load_use();
    rdy   = exp_ready();
    if (!rst) begin
      m = '0; mcnt = '0; init = 1;
      return;
    end
    if (id_valid && !rdy && mcnt != '1) mcnt = mcnt + 1'b1;
    n = m;
    if (flush || (!stuck && (lu || !id_valid))) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else if (!stuck) begin
      n.v = 1; n.pc = id_pc; n.imm = id_imm;
      n.rd1 = fwd(id_rs1, id_rd1); n.rd2 = fwd(id_rs2, id_rd2);
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.op = id_alu_op;
      n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
    end else begin
      n.rd1 = fwd(m.rs1, m.rd1);
      n.rd2 = fwd(m.rs2, m.rd2);
    end
    m = n;
  endtask

  // One clock: check id_ready before the edge, outputs after it.
  task automatic cyc();
    #1;
    if (init) chk("id_ready", id_ready, exp_ready());
    @(posedge clk);
    model_step();
    #1;
    chk("ex_valid", ex_valid, m.v);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rd1", ex_rd1, m.rd1);
    chk("ex_rd2", ex_rd2, m.rd2);
    chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
    chk("ex_ctl", {ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write}, {m.op, m.rw, m.mr, m.mw});
    chk("stall_cycles", stall_cycles, mcnt);
    @(negedge clk);
  endtask

  task automatic rnd_in();
    id_valid = ($urandom_range(99) < 80);
    id_pc = $urandom; id_imm = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
    id_rs1 = RA_W'($urandom_range(7)); id_rs2 = RA_W'($urandom_range(7));
    id_rd = RA_W'($urandom_range(7)); id_alu_op = 4'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(99) < 40);
    id_mem_write = 1'($urandom);
    wb_we = 1'($urandom); wb_rd = RA_W'($urandom_range(7)); wb_data = $urandom;
    flush = ($urandom_range(99) < 8);
    ex_ready = ($urandom_range(99) < 70);
    rst = ($urandom_range(99) >= 2);
  endtask

  task automatic set_id(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1, rs2, rd,
                        input logic mr);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_mem_read = mr;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_alu_op = 4'($urandom);
    id_reg_write = 1; id_mem_write = 0;
  endtask

  logic [CW-1:0] c0;

  initial begin
    rnd_in();
    wb_we = 0; flush = 0; ex_ready = 1;
    // Reset held for two cycles with decode presenting an instruction.
    rst = 0; set_id(32'h40, 1, 2, 3, 0);
    cyc(); cyc();
    chk("rst_all_zero", {ex_valid, ex_pc, ex_reg_write, ex_mem_read, stall_cycles}, '0);
    rst = 1; set_id(32'h100, 1, 2, 3, 0);
    cyc();
    chk("first_pc", ex_pc, 32'h100);

    // Streaming at full throughput.
    for (int i = 0; i < 4; i++) begin
      set_id(32'(i * 4), RA_W'(i + 1), RA_W'(i + 2), RA_W'(i + 3), 0);
      cyc();
      chk("stream_pc", ex_pc, 32'(i * 4));
    end
    chk("stream_stall", stall_cycles, 0);

    // Backpressure with bypass into the held rs1 operand.
    set_id(32'h200, 5, 6, 9, 0);
    cyc();
    ex_ready = 0; set_id(32'h204, 1, 2, 3, 0);
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    cyc();
    chk("hold_byp_rd1", ex_rd1, 32'hDEADBEEF);
    chk("hold_pc", ex_pc, 32'h200);
    wb_we = 0;
    cyc();
    chk("hold_stall", stall_cycles, 2);

    // Load-use: held lw x7, incoming instruction reads x7.
    ex_ready = 1; set_id(32'h300, 1, 2, 7, 1);
    cyc();
    c0 = stall_cycles;
    set_id(32'h304, 1, 7, 8, 0);
    cyc();
    chk("lu_bubble", {ex_valid, ex_reg_write}, 2'b00);
    cyc();
    chk("lu_accept", ex_pc, 32'h304);
    chk("lu_stall", stall_cycles, c0 + 1'b1);

    // Flush while EX is stalled kills held and incoming instructions.
    ex_ready = 0; set_id(32'h400, 1, 2, 3, 0);
    flush = 1;
    cyc();
    chk("flush_kill", ex_valid, 0);
    flush = 0; ex_ready = 1;

    // Writes to x0 are never forwarded.
    set_id(32'h500, 0, 2, 3, 0); id_rd1 = 0;
    wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
    cyc();
    chk("x0_no_byp", ex_rd1, 0);
    wb_we = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rnd_in();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
